qec_pulse_sequencer: RTL and testbench
======================================

Name: qec_pulse_sequencer

Overview:
- Bus master that drives the 3x3 qubit grid's register port (cs/we/addr/wdata/rdata) to run closed-loop error correction.
- Enables physics, programs pulse strength, samples the 9-bit syndrome, and applies correction pulses to flagged qubits.
- Holds each pulse by re-issuing the one-cycle pulse write every cycle for a programmed duration, because grid pulses are momentary.
- Sits between the RISC-V control CSRs (start/abort/config) and the grid.

Parameters:
- MAX_ROUNDS, 8, maximum pulse rounds before giving up (1..255).
- CNT_W, 16, width of the pulse and settle duration counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a correction run; ignored unless busy=0
- abort  in  1  stop run and disable physics
- cfg_strength  in  16  pulse strength; latched on accepted start
- cfg_pulse_cycles  in  CNT_W  cycles per pulse hold; latched on start; 0 is treated as 1
- cfg_settle_cycles  in  CNT_W  idle cycles after each pulse before resampling; latched on start; 0 means none
- grid_cs  out  1  grid chip select
- grid_we  out  1  grid write enable
- grid_addr  out  4  grid register address
- grid_wdata  out  32  grid write data
- grid_rdata  in  32  grid read data (combinational in grid)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on run completion
- converged  out  1  final syndrome was zero; valid from done until the next start
- rounds  out  8  pulse rounds executed in the last or current run
- last_syndrome  out  9  most recent sampled syndrome

Behaviour:
- Grid bus outputs are a Moore decode of state. With grid_cs=0, grid_we, grid_addr and grid_wdata are 0. Status outputs are registered.
- Reset: state IDLE; grid_cs, grid_we, grid_addr, grid_wdata, busy, done, converged, rounds, last_syndrome all 0; latched config 0.
- IDLE: on start=1 && abort=0:
  - latch config; clear rounds and converged;
  - next state CFG_EN.
  - abort=1 in IDLE goes to HALT (abort wins over start).
- CFG_EN (1 cycle): cs=1, we=1, addr=0x0, wdata=1. Next state CFG_STR.
- CFG_STR (1 cycle): cs=1, we=1, addr=0x3, wdata={16'b0, strength}. Next state SAMPLE.
- SAMPLE (1 cycle): cs=1, we=0, addr=0x2. Captures grid_rdata[8:0] into last_syndrome and a mask register at the end of the cycle.
  - Captured value zero: go to DONE with converged=1.
  - Nonzero and rounds==MAX_ROUNDS: go to DONE with converged=0.
  - Otherwise: rounds+1 and go to PULSE, loading pulse_cnt=max(cfg_pulse_cycles,1).
- PULSE: every cycle cs=1, we=1, addr=0x1, wdata={23'b0, mask}; pulse_cnt decrements.
  - On the cycle pulse_cnt==1, exit to SETTLE if cfg_settle_cycles!=0 (load settle_cnt), else to SAMPLE.
  - Exactly max(cfg_pulse_cycles,1) consecutive write cycles occur.
- SETTLE: cs=0; settle_cnt decrements; exit to SAMPLE on the cycle settle_cnt==1. Exactly cfg_settle_cycles idle cycles occur.
- DONE (1 cycle): done=1, cs=0; physics is left enabled. Next state IDLE.
- HALT (1 cycle): cs=1, we=1, addr=0x0, wdata=0. Next state IDLE. No done pulse; converged=0.
- abort=1 in any busy state except HALT: next state HALT. The current cycle's bus transaction still completes.
- Start-to-first-sample latency: SAMPLE is asserted 3 cycles after the start cycle.
- start while busy: ignored, with no effect on the latched config.
- Counters are CNT_W bits with no wrap: the maximum duration is 2^CNT_W-1.
- rst asserted mid-run: the next state is IDLE with all outputs at reset values. The grid is not explicitly disabled; its own reset covers it.

Test Plan:
- Grid model returns syndrome 0; start with strength=500, pulse=4, settle=2 -> exactly these bus cycles: write 0x0=1, write 0x3=500, read 0x2; then done at cycle 4, converged=1, rounds=0.
- Syndrome 0x005 on the first read, then 0 -> 4 consecutive writes of addr 0x1 data 0x005; 2 idle cycles; second read; done, converged=1, rounds=1, last_syndrome=0.
- Syndrome stuck at 0x1FF, MAX_ROUNDS=8 -> exactly 8 pulse bursts and 9 reads; done, converged=0, rounds=8.
- pulse=0, settle=0 with syndrome 0x010 then 0 -> one write of addr 0x1 data 0x010, immediately followed by SAMPLE.
- abort asserted on the 2nd PULSE cycle -> one HALT write of addr 0x0 data 0; then IDLE, busy=0, no done pulse.
- start pulsed while busy, and rst asserted mid-PULSE -> the start is ignored and config is unchanged; after rst, the next cycle has cs=0, busy=0, rounds=0 and state IDLE.

Source files
------------

// File: rtl/qec_pulse_sequencer.sv
// Closed-loop QEC bus master for the 3x3 qubit grid register port.
// Samples the syndrome, then holds correction pulses on the flagged qubits.
module qec_pulse_sequencer #(
  parameter int MAX_ROUNDS = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      cfg_strength,
  input  logic [CNT_W-1:0] cfg_pulse_cycles,
  input  logic [CNT_W-1:0] cfg_settle_cycles,
  output logic             grid_cs,
  output logic             grid_we,
  output logic [3:0]       grid_addr,
  output logic [31:0]      grid_wdata,
  input  logic [31:0]      grid_rdata,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic [7:0]       rounds,
  output logic [8:0]       last_syndrome
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_EN, S_CFG_STR, S_SAMPLE,
    S_PULSE, S_SETTLE, S_DONE, S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      str_q, str_d;
  logic [CNT_W-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [8:0]       mask_q, mask_d;
  logic [8:0]       syn_q, syn_d;
  logic [7:0]       rounds_q, rounds_d;
  logic             conv_q, conv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [8:0]       syn_w;
  logic             unused_rdata;

  assign syn_w        = grid_rdata[8:0];
  assign unused_rdata = ^grid_rdata[31:9];

  always_comb begin
    state_d  = state_q;
    str_d    = str_q;
    pulse_d  = pulse_q;
    settle_d = settle_q;
    pcnt_d   = pcnt_q;
    scnt_d   = scnt_q;
    mask_d   = mask_q;
    syn_d    = syn_q;
    rounds_d = rounds_q;
    conv_d   = conv_q;
    unique case (state_q)
      S_IDLE: begin
        if (abort) begin
          state_d = S_HALT;
        end else if (start) begin
          str_d    = cfg_strength;
          pulse_d  = cfg_pulse_cycles;
          settle_d = cfg_settle_cycles;
          rounds_d = '0;
          conv_d   = 1'b0;
          state_d  = S_CFG_EN;
        end
      end
      S_CFG_EN:  state_d = S_CFG_STR;
      S_CFG_STR: state_d = S_SAMPLE;
      S_SAMPLE: begin
        syn_d  = syn_w;
        mask_d = syn_w;
        if (syn_w == '0) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else if (rounds_q == 8'(MAX_ROUNDS)) begin
          conv_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          rounds_d = rounds_q + 8'd1;
          pcnt_d   = (pulse_q == '0) ? CNT_W'(1) : pulse_q;
          state_d  = S_PULSE;
        end
      end
      S_PULSE: begin
        if (pcnt_q <= CNT_W'(1)) begin
          if (settle_q != '0) begin
            scnt_d  = settle_q;
            state_d = S_SETTLE;
          end else begin
            state_d = S_SAMPLE;
          end
        end else begin
          pcnt_d = pcnt_q - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (scnt_q <= CNT_W'(1)) state_d = S_SAMPLE;
        else scnt_d = scnt_q - CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      S_HALT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort overrides the sequencing but the cycle's bus access still lands
    if (abort && state_q != S_IDLE && state_q != S_HALT) begin
      state_d  = S_HALT;
      rounds_d = rounds_q;
    end
    if (state_d == S_HALT) conv_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_comb begin
    grid_cs    = 1'b0;
    grid_we    = 1'b0;
    grid_addr  = 4'h0;
    grid_wdata = 32'h0;
    unique case (state_q)
      S_CFG_EN: begin
        grid_cs    = 1'b1;
        grid_we    = 1'b1;
        grid_wdata = 32'd1;
      end
      S_CFG_STR: begin
        grid_cs    = 1'b1;
        grid_we    = 1'b1;
        grid_addr  = 4'h3;
        grid_wdata = {16'b0, str_q};
      end
      S_SAMPLE: begin
        grid_cs   = 1'b1;
        grid_addr = 4'h2;
      end
      S_PULSE: begin
        grid_cs    = 1'b1;
        grid_we    = 1'b1;
        grid_addr  = 4'h1;
        grid_wdata = {23'b0, mask_q};
      end
      S_HALT: begin
        grid_cs = 1'b1;
        grid_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      str_q    <= '0;
      pulse_q  <= '0;
      settle_q <= '0;
      pcnt_q   <= '0;
      scnt_q   <= '0;
      mask_q   <= '0;
      syn_q    <= '0;
      rounds_q <= '0;
      conv_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      str_q    <= str_d;
      pulse_q  <= pulse_d;
      settle_q <= settle_d;
      pcnt_q   <= pcnt_d;
      scnt_q   <= scnt_d;
      mask_q   <= mask_d;
      syn_q    <= syn_d;
      rounds_q <= rounds_d;
      conv_q   <= conv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign converged     = conv_q;
  assign rounds        = rounds_q;
  assign last_syndrome = syn_q;

endmodule

// File: tb/tb_qec_pulse_sequencer.sv
// Bench for qec_pulse_sequencer: grid model plus a per-cycle bus
// transaction list derived from the correction-loop rules.
module tb_qec_pulse_sequencer;

  localparam int MR = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   cfg_strength = '0;
  logic [CW-1:0] cfg_pulse_cycles = '0;
  logic [CW-1:0] cfg_settle_cycles = '0;
  logic          grid_cs, grid_we;
  logic [3:0]    grid_addr;
  logic [31:0]   grid_wdata, grid_rdata;
  logic          busy, done, converged;
  logic [7:0]    rounds;
  logic [8:0]    last_syndrome;

  qec_pulse_sequencer #(.MAX_ROUNDS(MR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_strength(cfg_strength),
    .cfg_pulse_cycles(cfg_pulse_cycles),
    .cfg_settle_cycles(cfg_settle_cycles),
    .grid_cs(grid_cs), .grid_we(grid_we),
    .grid_addr(grid_addr), .grid_wdata(grid_wdata),
    .grid_rdata(grid_rdata),
    .busy(busy), .done(done), .converged(converged),
    .rounds(rounds), .last_syndrome(last_syndrome)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // grid model: syndrome sequence, last entry repeats
  logic [8:0] syn_arr [32];
  int         syn_n = 1;
  int         rd_idx = 0;
  logic       rd_clr = 1'b0;

  initial syn_arr[0] = '0;

  assign grid_rdata = {23'h2D2D2D,
    syn_arr[(rd_idx < syn_n) ? rd_idx : syn_n - 1]};

  always @(posedge clk) begin
    if (rd_clr) rd_idx <= 0;
    else if (grid_cs && !grid_we && grid_addr == 4'h2)
      rd_idx <= rd_idx + 1;
  end

  wire [37:0] bus_w = {grid_cs, grid_we, grid_addr, grid_wdata};

  function automatic logic [37:0] w(input logic cs, input logic we,
                                    input logic [3:0] a,
                                    input logic [31:0] d);
    return {cs, we, a, d};
  endfunction

  logic [37:0] tr [$];
  logic [37:0] ex [$];
  int          ex_rounds;
  logic        ex_conv;
  logic [8:0]  ex_last;

  // expected bus activity, one entry per cycle from the cycle after start
  task automatic model(input logic [15:0] s, input int p, input int st);
    int r = 0;
    int k = 0;
    int np;
    logic [8:0] v;
    ex.delete();
    ex.push_back(w(1, 1, 4'h0, 32'd1));
    ex.push_back(w(1, 1, 4'h3, {16'b0, s}));
    np = (p < 1) ? 1 : p;
    forever begin
      v = syn_arr[(k < syn_n) ? k : syn_n - 1];
      k++;
      ex.push_back(w(1, 0, 4'h2, 32'd0));
      ex_last = v;
      if (v == 0) begin ex_conv = 1'b1; break; end
      if (r == MR) begin ex_conv = 1'b0; break; end
      r++;
      repeat (np) ex.push_back(w(1, 1, 4'h1, {23'b0, v}));
      repeat (st) ex.push_back('0);
    end
    ex_rounds = r;
    ex.push_back('0);
  endtask

  task automatic launch(input logic [15:0] s, input int p, input int st);
    @(negedge clk);
    abort = 1'b0;
    cfg_strength = s;
    cfg_pulse_cycles = CW'(p);
    cfg_settle_cycles = CW'(st);
    start = 1'b1;
    rd_clr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd_clr = 1'b0;
  endtask

  task automatic collect(input bit poke, output bit ok);
    ok = 1'b0;
    tr.delete();
    for (int i = 0; i < 3000; i++) begin
      if (poke && i == 0) begin
        start = 1'b1;
        cfg_strength = 16'hBEEF;
        cfg_pulse_cycles = CW'(1);
        cfg_settle_cycles = CW'(0);
      end
      if (poke && i == 1) start = 1'b0;
      tr.push_back(bus_w);
      if (done) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic run(input logic [15:0] s, input int p, input int st,
                     input bit poke, output bit ok);
    model(s, p, st);
    launch(s, p, st);
    collect(poke, ok);
  endtask

  function automatic int first_diff();
    int n = (tr.size() < ex.size()) ? tr.size() : ex.size();
    for (int i = 0; i < n; i++) if (tr[i] !== ex[i]) return i;
    if (tr.size() != ex.size()) return n;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus_w !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_bus got %h want 0", bus_w);
    end
    n_tests++;
    if ({busy, done, converged} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000",
               {busy, done, converged});
    end
    n_tests++;
    if ({rounds, last_syndrome} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_status got %h want 0",
               {rounds, last_syndrome});
    end
    rst = 1'b0;
  endtask

  task automatic test_converge_now();
    bit ok;
    int d;
    syn_n = 1; syn_arr[0] = 9'h000;
    run(16'd500, 4, 2, 1'b0, ok);
    d = first_diff();
    n_tests++;
    if (!ok || d >= 0) begin
      n_fail++;
      $display("FAIL conv_now_trace idx %0d got %h want %h len %0d/%0d",
               d, tr[d], ex[d], tr.size(), ex.size());
    end
    n_tests++;
    if ({converged, rounds} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL conv_now_status got %b/%0d want 1/0",
               converged, rounds);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL conv_now_idle busy %b done %b want 0 0", busy, done);
    end
  endtask

  task automatic test_one_round();
    bit ok;
    int d;
    syn_n = 2; syn_arr[0] = 9'h005; syn_arr[1] = 9'h000;
    run(16'd77, 4, 2, 1'b0, ok);
    d = first_diff();
    n_tests++;
    if (!ok || d >= 0) begin
      n_fail++;
      $display("FAIL one_round_trace idx %0d got %h want %h len %0d/%0d",
               d, tr[d], ex[d], tr.size(), ex.size());
    end
    n_tests++;
    if ({converged, rounds, last_syndrome} !== {1'b1, 8'd1, 9'd0}) begin
      n_fail++;
      $display("FAIL one_round_status got %b/%0d/%h want 1/1/0",
               converged, rounds, last_syndrome);
    end
  endtask

  task automatic test_stuck();
    bit ok;
    int d;
    int reads;
    syn_n = 1; syn_arr[0] = 9'h1FF;
    run(16'd3, 2, 1, 1'b0, ok);
    d = first_diff();
    n_tests++;
    if (!ok || d >= 0) begin
      n_fail++;
      $display("FAIL stuck_trace idx %0d got %h want %h len %0d/%0d",
               d, tr[d], ex[d], tr.size(), ex.size());
    end
    reads = 0;
    foreach (tr[i]) if (tr[i][37:32] == 6'b10_0010) reads++;
    n_tests++;
    if (reads != MR + 1) begin
      n_fail++;
      $display("FAIL stuck_reads got %0d want %0d", reads, MR + 1);
    end
    n_tests++;
    if ({converged, rounds, last_syndrome} !==
        {1'b0, 8'(MR), 9'h1FF}) begin
      n_fail++;
      $display("FAIL stuck_status got %b/%0d/%h want 0/%0d/1ff",
               converged, rounds, last_syndrome, MR);
    end
  endtask

  task automatic test_zero_durations();
    bit ok;
    int d;
    syn_n = 2; syn_arr[0] = 9'h010; syn_arr[1] = 9'h000;
    run(16'hFFFF, 0, 0, 1'b0, ok);
    d = first_diff();
    n_tests++;
    if (!ok || d >= 0) begin
      n_fail++;
      $display("FAIL zero_dur_trace idx %0d got %h want %h len %0d/%0d",
               d, tr[d], ex[d], tr.size(), ex.size());
    end
    n_tests++;
    if (tr[3] !== w(1, 1, 4'h1, 32'h010) ||
        tr[4] !== w(1, 0, 4'h2, 32'h0)) begin
      n_fail++;
      $display("FAIL zero_dur_pulse got %h %h want single pulse then read",
               tr[3], tr[4]);
    end
  endtask

  task automatic test_abort();
    bit seen;
    int dones;
    syn_n = 1; syn_arr[0] = 9'h003;
    launch(16'd7, 4, 2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_w == w(1, 1, 4'h1, 32'h3)) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL abort_no_pulse got none want pulse write");
    end
    @(negedge clk);
    n_tests++;
    if (bus_w !== w(1, 1, 4'h1, 32'h3)) begin
      n_fail++;
      $display("FAIL abort_2nd_pulse got %h want pulse write", bus_w);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if (bus_w !== w(1, 1, 4'h0, 32'h0) || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_halt got %h done %b want %h done 0",
               bus_w, done, w(1, 1, 4'h0, 32'h0));
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || grid_cs !== 1'b0 || converged !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle busy %b cs %b conv %b want 0 0 0",
               busy, grid_cs, converged);
    end
    dones = 0;
    repeat (5) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL abort_done got %0d pulses want 0", dones);
    end
    // abort while idle still issues the disable write
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if (bus_w !== w(1, 1, 4'h0, 32'h0) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle_halt got %h busy %b want halt busy 1",
               bus_w, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_start_and_rst();
    bit ok;
    int d;
    bit seen;
    syn_n = 2; syn_arr[0] = 9'h011; syn_arr[1] = 9'h000;
    run(16'h1234, 3, 1, 1'b1, ok);
    d = first_diff();
    n_tests++;
    if (!ok || d >= 0) begin
      n_fail++;
      $display("FAIL busy_start_trace idx %0d got %h want %h len %0d/%0d",
               d, tr[d], ex[d], tr.size(), ex.size());
    end
    @(negedge clk);
    syn_n = 1; syn_arr[0] = 9'h1FF;
    launch(16'd9, 5, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (grid_cs && grid_we && grid_addr == 4'h1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (!seen || grid_cs !== 1'b0 || busy !== 1'b0 ||
        rounds !== 8'd0 || last_syndrome !== 9'd0 ||
        converged !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid seen %b cs %b busy %b rounds %0d syn %h",
               seen, grid_cs, busy, rounds, last_syndrome);
    end
    @(negedge clk);
    n_tests++;
    if (bus_w !== 38'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle got %h busy %b want 0 0", bus_w, busy);
    end
  endtask

  task automatic test_random();
    bit ok;
    int d;
    int p, st;
    logic [15:0] s;
    for (int it = 0; it < 25; it++) begin
      syn_n = $urandom_range(1, 10);
      for (int i = 0; i < syn_n; i++)
        syn_arr[i] = ($urandom_range(0, 3) == 0) ? 9'd0
                     : 9'($urandom_range(1, 511));
      p  = $urandom_range(0, 5);
      st = $urandom_range(0, 4);
      s  = 16'($urandom);
      run(s, p, st, 1'b0, ok);
      d = first_diff();
      n_tests++;
      if (!ok || d >= 0) begin
        n_fail++;
        $display("FAIL rand%0d_trace idx %0d got %h want %h", it,
                 d, tr[d], ex[d]);
      end
      n_tests++;
      if ({converged, rounds, last_syndrome} !==
          {ex_conv, 8'(ex_rounds), ex_last}) begin
        n_fail++;
        $display("FAIL rand%0d_status got %b/%0d/%h want %b/%0d/%h", it,
                 converged, rounds, last_syndrome,
                 ex_conv, ex_rounds, ex_last);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_converge_now();
    test_one_round();
    test_stuck();
    test_zero_durations();
    test_abort();
    test_busy_start_and_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
